// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: pipelined floating-point multiplier with valid/ready flow control
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [4:0]             flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int P = MAN_W + 1;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  logic advance;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, bad_op, sign;
  logic [2*P-1:0] ma, mb;
  logic [W-1:0] spr_c;
  logic [4:0] spf_c;
  logic v1, sg1, sp1;
  logic [W-1:0] spr1;
  logic [4:0] spf1;
  logic signed [XW-1:0] e1;
  logic [2*P-1:0] p1;
  logic v2, sg2, sp2, g2, s2;
  logic [W-1:0] spr2;
  logic [4:0] spf2;
  logic signed [XW-1:0] e2;
  logic [MAN_W-1:0] m2;
  logic v3, sg3, sp3, x3;
  logic [W-1:0] spr3;
  logic [4:0] spf3;
  logic signed [XW-1:0] e3;
  logic [MAN_W-1:0] f3;
  logic hi, ovf, unf;
  logic [MAN_W:0] mr;
  logic [W-1:0] res_c;
  logic [4:0] flg_c;
  assign advance = !out_valid || out_ready;
  assign in_ready = advance;
  assign {ea, fa} = a[W-2:0];
  assign {eb, fb} = b[W-2:0];
  assign a_zero = ea == '0;
  assign b_zero = eb == '0;
  assign a_inf = &ea && fa == '0;
  assign b_inf = &eb && fb == '0;
  assign a_nan = &ea && fa != '0;
  assign b_nan = &eb && fb != '0;
  assign bad_op = (a_inf && b_zero) || (b_inf && a_zero);
  assign sign = a[W-1] ^ b[W-1];
  assign ma = {{P{1'b0}}, 1'b1, fa};
  assign mb = {{P{1'b0}}, 1'b1, fb};
  assign spr_c = (a_nan || b_nan || bad_op) ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}} :
                 (a_inf || b_inf) ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sign, {(W-1){1'b0}}};
  assign spf_c = (a_nan || b_nan || bad_op) ?
                 {bad_op || (a_nan && !fa[MAN_W-1]) || (b_nan && !fb[MAN_W-1]), 4'b0000} :
                 (a_inf || b_inf) ? 5'b00000 : 5'b00001;
  assign hi = p1[2*P-1];
  assign mr = {1'b0, m2} + {{MAN_W{1'b0}}, g2 && (s2 || m2[0])};
  assign ovf = e3 >= EMAX;
  assign unf = e3[XW-1] || e3 == '0;
  assign res_c = sp3 ? spr3 : ovf ? {sg3, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                 unf ? {sg3, {(W-1){1'b0}}} : {sg3, e3[EXP_W-1:0], f3};
  assign flg_c = sp3 ? spf3 : ovf ? 5'b01010 : unf ? 5'b00111 : {3'b000, x3, 1'b0};
  // valid bits and output registers; the whole pipe freezes while the output is blocked
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
      flags <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      out_valid <= v3;
      if (v3) begin
        result <= res_c;
        flags <= flg_c;
      end
    end
  end
  // datapath: unpack/multiply, normalise with guard/sticky, round to nearest even
  always_ff @(posedge clk) begin
    if (advance) begin
      sg1 <= sign;
      sp1 <= a_zero || b_zero || &ea || &eb;
      spr1 <= spr_c;
      spf1 <= spf_c;
      e1 <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
      p1 <= ma * mb;
      sg2 <= sg1;
      sp2 <= sp1;
      spr2 <= spr1;
      spf2 <= spf1;
      e2 <= e1 + $signed(XW'(hi));
      m2 <= hi ? p1[2*P-2 -: MAN_W] : p1[2*P-3 -: MAN_W];
      g2 <= hi ? p1[P-1] : p1[P-2];
      s2 <= hi ? |p1[P-2:0] : |p1[P-3:0];
      sg3 <= sg2;
      sp3 <= sp2;
      spr3 <= spr2;
      spf3 <= spf2;
      e3 <= e2 + $signed(XW'(mr[MAN_W]));
      f3 <= mr[MAN_W-1:0];
      x3 <= g2 || s2;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: randomized and directed checks of fp_mul_pipe against an arithmetic model
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid;
  logic [31:0] a = '0, b = '0, result;
  logic [4:0] flags;
  logic h_in_valid = 1'b0, h_in_ready, h_out_valid;
  logic [15:0] ha = '0, hb = '0, h_result;
  logic [4:0] h_flags;
  int total = 0, bad = 0;
  logic [36:0] sb[$];

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(ha), .b(hb),
    .out_valid(h_out_valid), .out_ready(1'b1), .result(h_result), .flags(h_flags)
  );

  // exact product value, rounded by remainder comparison; returns {flags, result}
  function automatic logic [36:0] ref_mul(input int ew, input int mw, input logic [31:0] x, input logic [31:0] y);
    longint unsigned emask = (64'd1 << ew) - 1;
    longint unsigned fmask = (64'd1 << mw) - 1;
    longint unsigned ex = (64'(x) >> mw) & emask;
    longint unsigned ey = (64'(y) >> mw) & emask;
    longint unsigned fx = 64'(x) & fmask;
    longint unsigned fy = 64'(y) & fmask;
    bit s = x[ew+mw] ^ y[ew+mw];
    longint unsigned sbit = s ? (64'd1 << (ew + mw)) : 64'd0;
    longint unsigned inf = sbit | (emask << mw);
    longint unsigned qnan = (emask << mw) | (64'd1 << (mw - 1));
    bit nx = ex == emask && fx != 0;
    bit ny = ey == emask && fy != 0;
    bit ix = ex == emask && fx == 0;
    bit iy = ey == emask && fy == 0;
    bit zx = ex == 0;
    bit zy = ey == 0;
    longint unsigned mp, q, r, half;
    int k;
    longint be;
    if (nx || ny || (ix && zy) || (iy && zx))
      return {(ix && zy) || (iy && zx) || (nx && !fx[mw-1]) || (ny && !fy[mw-1]), 4'b0000, qnan[31:0]};
    if (ix || iy) return {5'b00000, inf[31:0]};
    if (zx || zy) return {5'b00001, sbit[31:0]};
    mp = ((64'd1 << mw) | fx) * ((64'd1 << mw) | fy);
    k = mw;
    while ((mp >> k) >= (64'd2 << mw)) k++;
    q = mp >> k;
    r = mp - (q << k);
    half = 64'd1 << (k - 1);
    if (r > half || (r == half && q[0])) q++;
    if (q == (64'd2 << mw)) begin
      q = q >> 1;
      k++;
    end
    be = longint'(ex + ey) - longint'((64'd1 << (ew - 1)) - 1) + longint'(k - mw);
    if (be >= longint'(emask)) return {5'b01010, inf[31:0]};
    if (be <= 0) return {5'b00111, sbit[31:0]};
    q = sbit | ($unsigned(be) << mw) | (q & fmask);
    return {3'b000, r != 0, 1'b0, q[31:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v = $urandom;
    int sel = $urandom_range(0, 9);
    if (sel == 0) v[30:23] = 8'h00;
    else if (sel == 1) begin
      v[30:23] = 8'hFF;
      if ($urandom_range(0, 1) == 1) v[22:0] = '0;
    end
    else if (sel == 2) v[30:23] = 8'($urandom_range(1, 8));
    else if (sel == 3) v[30:23] = 8'($urandom_range(240, 254));
    else v[30:23] = 8'($urandom_range(100, 154));
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    a = 32'h3FA00000;
    b = 32'h3F400000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=00000000", result); end
    total++;
    if (flags !== 5'h0) begin bad++; $display("FAIL reset_flags got=%b want=00000", flags); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_no_output c=%0d got=%b want=0", c, out_valid); end
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[8] = '{32'h3FA00000, 32'h411C0000, 32'h3F800001, 32'h3F800001,
                           32'h7F000000, 32'h7F800000, 32'h00800000, 32'h80000000};
    logic [31:0] vb[8] = '{32'h3F400000, 32'hBF100000, 32'h3F800001, 32'h3FC00000,
                           32'h40000000, 32'h00000000, 32'h00800000, 32'h3F800000};
    logic [36:0] ve[8] = '{{5'b00000, 32'h3F700000}, {5'b00000, 32'hC0AF8000},
                           {5'b00010, 32'h3F800002}, {5'b00010, 32'h3FC00002},
                           {5'b01010, 32'h7F800000}, {5'b10000, 32'h7FC00000},
                           {5'b00111, 32'h00000000}, {5'b00001, 32'h80000000}};
    out_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      in_valid = c < 8;
      a = c < 8 ? va[c] : 32'h0;
      b = c < 8 ? vb[c] : 32'h0;
      #1;
      total++;
      if (out_valid !== (c >= 4 && c < 12)) begin
        bad++;
        $display("FAIL directed_latency c=%0d got=%b want=%b", c, out_valid, c >= 4 && c < 12);
      end
      if (c >= 4 && c < 12) begin
        total++;
        if ({flags, result} !== ve[c-4]) begin
          bad++;
          $display("FAIL directed_%0d got=%b/%h want=%b/%h", c - 4, flags, result, ve[c-4][36:32], ve[c-4][31:0]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa[8], xb[8];
    logic [36:0] hold, e;
    int sent = 0, got = 0;
    for (int i = 0; i < 8; i++) begin
      xa[i] = rnd_op();
      xb[i] = rnd_op();
    end
    sb.delete();
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 11);
      in_valid = sent < 8;
      a = sent < 8 ? xa[sent] : 32'h0;
      b = sent < 8 ? xb[sent] : 32'h0;
      #1;
      if (c >= 7 && c < 11) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready c=%0d got=%b want=0", c, in_ready); end
        total++;
        if ({flags, result} !== hold) begin
          bad++;
          $display("FAIL stall_hold c=%0d got=%b/%h want=%b/%h", c, flags, result, hold[36:32], hold[31:0]);
        end
      end
      hold = {flags, result};
      if (out_valid && out_ready) begin
        got++;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL b2b_extra got=%h want=none", result); end
        else begin
          e = sb.pop_front();
          if ({flags, result} !== e) begin
            bad++;
            $display("FAIL b2b_result got=%b/%h want=%b/%h", flags, result, e[36:32], e[31:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_mul(8, 23, a, b));
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got); end
  endtask

  task automatic test_random();
    logic [36:0] e;
    sb.delete();
    for (int c = 0; c < 320; c++) begin
      @(negedge clk);
      if (c < 300) begin
        in_valid = $urandom_range(0, 9) < 7;
        out_ready = $urandom_range(0, 9) < 7;
        a = rnd_op();
        b = rnd_op();
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      total++;
      if (in_ready !== (!out_valid || out_ready)) begin
        bad++;
        $display("FAIL rand_in_ready c=%0d got=%b want=%b", c, in_ready, !out_valid || out_ready);
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL rand_extra got=%h want=none", result); end
        else begin
          e = sb.pop_front();
          if ({flags, result} !== e) begin
            bad++;
            $display("FAIL rand_result got=%b/%h want=%b/%h", flags, result, e[36:32], e[31:0]);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(ref_mul(8, 23, a, b));
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL rand_drain got=%0d want=0 pending", sb.size()); end
  endtask

  task automatic test_reset_midflight();
    logic [36:0] e;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'h3FA00000;
    b = 32'h3F400000;
    @(negedge clk);
    a = 32'h411C0000;
    b = 32'hBF100000;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_quiet c=%0d got=%b want=0", c, out_valid); end
      @(negedge clk);
    end
    in_valid = 1'b1;
    a = {2'b00, 6'($urandom_range(10, 50)), 24'($urandom)};
    b = {2'b10, 6'($urandom_range(10, 50)), 24'($urandom)};
    e = ref_mul(8, 23, a, b);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== (k == 4)) begin bad++; $display("FAIL midreset_latency k=%0d got=%b want=%b", k, out_valid, k == 4); end
    end
    total++;
    if ({flags, result} !== e) begin
      bad++;
      $display("FAIL midreset_result got=%b/%h want=%b/%h", flags, result, e[36:32], e[31:0]);
    end
  endtask

  task automatic test_half();
    logic [15:0] da[2] = '{16'h3C00, 16'h7BFF};
    logic [15:0] db[2] = '{16'h4000, 16'h4000};
    logic [20:0] de[2] = '{{5'b00000, 16'h4000}, {5'b01010, 16'h7C00}};
    logic [20:0] q16[$];
    logic [20:0] e;
    logic [36:0] r;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      h_in_valid = c < 42;
      ha = c < 2 ? da[c] : 16'($urandom);
      hb = c < 2 ? db[c] : 16'($urandom);
      #1;
      if (h_out_valid) begin
        total++;
        if (q16.size() == 0) begin bad++; $display("FAIL half_extra got=%h want=none", h_result); end
        else begin
          e = q16.pop_front();
          if ({h_flags, h_result} !== e) begin
            bad++;
            $display("FAIL half_result got=%b/%h want=%b/%h", h_flags, h_result, e[20:16], e[15:0]);
          end
        end
      end
      if (h_in_valid && h_in_ready) begin
        r = ref_mul(5, 10, {16'h0, ha}, {16'h0, hb});
        q16.push_back(c < 2 ? de[c] : {r[36:32], r[15:0]});
      end
    end
    h_in_valid = 1'b0;
    total++;
    if (q16.size() != 0) begin bad++; $display("FAIL half_drain got=%0d want=0 pending", q16.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_half();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
